mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-port arbiter in front of a single-port synchronous data memory.
//   Port A (core MEM stage) normally wins. Port B (loader/debug host) is
//   protected from starvation by a denial counter, and can take exclusive
//   back-to-back ownership with b_lock for a bounded burst.
//
// Ports
//   w_clk, w_rst                  clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata     port A request (write when a_we=1)
//   a_gnt                         port A accepted this cycle
//   a_rvalid/a_rdata              port A read response, one cycle after grant
//   b_*                           port B, same meaning as port A
//   b_lock                        port B requests exclusive ownership
//   mem_addr/mem_we/mem_wdata     memory command (from the granted port)
//   mem_rdata                     memory read data, one cycle after address
//   a_stall_cnt                   saturating count of denied A cycles
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_ARB   | normal arbitration, A first unless B has hit the starve limit
// ST_LOCK  | B owns the memory; A blocked while b_lock stays high
// ST_YIELD | one cycle after a full burst; A has absolute priority
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int MAX_BURST    = 16
) (
   input  logic        w_clk,
   input  logic        w_rst,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [11:0] a_addr,
   input  logic [31:0] a_wdata,
   output logic        a_gnt,
   output logic        a_rvalid,
   output logic [31:0] a_rdata,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [11:0] b_addr,
   input  logic [31:0] b_wdata,
   input  logic        b_lock,
   output logic        b_gnt,
   output logic        b_rvalid,
   output logic [31:0] b_rdata,
   output logic [11:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [15:0] a_stall_cnt
);

   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam int BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {ST_ARB, ST_LOCK, ST_YIELD} state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] starve_cnt;
   logic [BW-1:0] burst_cnt, burst_nxt;
   logic          starved;
   logic          arb_a, arb_b;
   logic          a_rv_q, b_rv_q;

   assign starved = b_req && (starve_cnt == SW'(STARVE_LIMIT));
   assign arb_a   = a_req && !starved;
   assign arb_b   = b_req && !arb_a;

   always_comb begin
      a_gnt     = 1'b0;
      b_gnt     = 1'b0;
      state_nxt = state;
      burst_nxt = burst_cnt;
      if (!w_rst) begin
         case (state)
            ST_LOCK: begin
               if (b_lock) begin
                  // With b_req low the lock still holds and A stays blocked.
                  b_gnt = b_req;
                  if (b_req) begin
                     burst_nxt = burst_cnt + 1'b1;
                     if (burst_nxt == BW'(MAX_BURST))
                        state_nxt = ST_YIELD;
                  end
               end else begin
                  // Lock released: this cycle is arbitrated as ARB.
                  a_gnt     = arb_a;
                  b_gnt     = arb_b;
                  state_nxt = ST_ARB;
                  burst_nxt = '0;
               end
            end
            ST_YIELD: begin
               a_gnt     = a_req;
               b_gnt     = b_req && !a_req;
               state_nxt = ST_ARB;
               burst_nxt = '0;
            end
            default: begin
               a_gnt = arb_a;
               b_gnt = arb_b;
               if (arb_b && b_lock) begin
                  burst_nxt = BW'(1);
                  state_nxt = (MAX_BURST <= 1) ? ST_YIELD : ST_LOCK;
               end
            end
         endcase
      end
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         state       <= ST_ARB;
         starve_cnt  <= '0;
         burst_cnt   <= '0;
         a_stall_cnt <= '0;
         a_rv_q      <= 1'b0;
         b_rv_q      <= 1'b0;
      end else begin
         state     <= state_nxt;
         burst_cnt <= burst_nxt;
         if (!b_req || b_gnt)
            starve_cnt <= '0;
         else if (starve_cnt != SW'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 1'b1;
         if (a_req && !a_gnt && (a_stall_cnt != 16'hFFFF))
            a_stall_cnt <= a_stall_cnt + 16'd1;
         a_rv_q <= a_gnt && !a_we;
         b_rv_q <= b_gnt && !b_we;
      end
   end

   // Gating with w_rst hides a response to a read granted just before reset.
   assign a_rvalid  = a_rv_q && !w_rst;
   assign b_rvalid  = b_rv_q && !w_rst;
   assign a_rdata   = mem_rdata;
   assign b_rdata   = mem_rdata;

   assign mem_addr  = b_gnt ? b_addr  : a_addr;
   assign mem_wdata = b_gnt ? b_wdata : a_wdata;
   assign mem_we    = (a_gnt && a_we) || (b_gnt && b_we);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter with a behavioural single-port synchronous memory.
module tb_mem_arbiter;

   logic        w_clk = 1'b0;
   logic        w_rst;
   logic        a_req, a_we, a_gnt, a_rvalid;
   logic [11:0] a_addr;
   logic [31:0] a_wdata, a_rdata;
   logic        b_req, b_we, b_lock, b_gnt, b_rvalid;
   logic [11:0] b_addr;
   logic [31:0] b_wdata, b_rdata;
   logic [11:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata, mem_rdata;
   logic [15:0] a_stall_cnt;

   logic [31:0] mem [0:4095];
   int n_checks = 0;
   int n_fail   = 0;

   mem_arbiter #(.STARVE_LIMIT(4), .MAX_BURST(16)) dut (
      .w_clk(w_clk), .w_rst(w_rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_lock(b_lock), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .a_stall_cnt(a_stall_cnt)
   );

   always #5 w_clk = ~w_clk;

   always @(posedge w_clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   task tick;
      @(posedge w_clk);
      #1;
   endtask

   task idle_inputs;
      a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_lock = 0;
   endtask

   task do_reset;
      w_rst = 1;
      idle_inputs();
      tick();
      tick();
      w_rst = 0;
   endtask

   task test_reset;
      w_rst = 1;
      a_req = 1; a_we = 1; b_req = 1; b_we = 1; b_lock = 1;
      @(negedge w_clk);
      n_checks++;
      if ({a_gnt, b_gnt, mem_we} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_grants: got a/b/we=%b want 000", {a_gnt, b_gnt, mem_we});
      end
      tick();
      tick();
      idle_inputs();
      w_rst = 0;
      @(negedge w_clk);
      n_checks++;
      if (a_stall_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_stall: got %0d want 0", a_stall_cnt);
      end
      n_checks++;
      if ({a_rvalid, b_rvalid} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_rvalid: got %b want 00", {a_rvalid, b_rvalid});
      end
      tick();
   endtask

   task test_a_read;
      mem[12'h010] = 32'hDEADBEEF;
      idle_inputs();
      a_req = 1; a_addr = 12'h010;
      @(negedge w_clk);
      n_checks++;
      if ({a_gnt, b_gnt, mem_we} !== 3'b100) begin
         n_fail++;
         $display("FAIL aread_gnt: got a/b/we=%b want 100", {a_gnt, b_gnt, mem_we});
      end
      n_checks++;
      if (mem_addr !== 12'h010) begin
         n_fail++;
         $display("FAIL aread_addr: got %h want 010", mem_addr);
      end
      tick();
      idle_inputs();
      @(negedge w_clk);
      n_checks++;
      if ({a_rvalid, b_rvalid} !== 2'b10) begin
         n_fail++;
         $display("FAIL aread_rvalid: got a/b=%b want 10", {a_rvalid, b_rvalid});
      end
      n_checks++;
      if (a_rdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL aread_rdata: got %h want deadbeef", a_rdata);
      end
      tick();
      @(negedge w_clk);
      n_checks++;
      if (a_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL aread_rvalid_once: got %b want 0", a_rvalid);
      end
      tick();
   endtask

   task test_starvation;
      logic exp_b;
      do_reset();
      a_req = 1; a_addr = 12'h001; b_req = 1; b_addr = 12'h002;
      for (int c = 0; c < 10; c++) begin
         exp_b = (c == 4) || (c == 9);
         @(negedge w_clk);
         n_checks++;
         if ({a_gnt, b_gnt} !== {~exp_b, exp_b}) begin
            n_fail++;
            $display("FAIL starve_gnt c%0d: got a/b=%b want %b", c, {a_gnt, b_gnt}, {~exp_b, exp_b});
         end
         n_checks++;
         if (mem_addr !== (exp_b ? 12'h002 : 12'h001)) begin
            n_fail++;
            $display("FAIL starve_addr c%0d: got %h want %h", c, mem_addr, exp_b ? 12'h002 : 12'h001);
         end
         tick();
      end
      idle_inputs();
      @(negedge w_clk);
      n_checks++;
      if (a_stall_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL starve_stall: got %0d want 2", a_stall_cnt);
      end
      n_checks++;
      if ({a_rvalid, b_rvalid} !== 2'b01) begin
         n_fail++;
         $display("FAIL starve_rvalid: got a/b=%b want 01", {a_rvalid, b_rvalid});
      end
      tick();
   endtask

   task test_b_write_read;
      do_reset();
      b_req = 1; b_we = 1; b_addr = 12'h123; b_wdata = 32'h55AA55AA;
      @(negedge w_clk);
      n_checks++;
      if ({b_gnt, mem_we} !== 2'b11 || mem_addr !== 12'h123 || mem_wdata !== 32'h55AA55AA) begin
         n_fail++;
         $display("FAIL bwrite_cmd: got gnt/we=%b addr=%h data=%h want 11 123 55aa55aa",
                  {b_gnt, mem_we}, mem_addr, mem_wdata);
      end
      tick();
      b_we = 0;
      @(negedge w_clk);
      n_checks++;
      if ({b_gnt, mem_we, b_rvalid} !== 3'b100) begin
         n_fail++;
         $display("FAIL bread_cmd: got gnt/we/rvalid=%b want 100", {b_gnt, mem_we, b_rvalid});
      end
      tick();
      idle_inputs();
      @(negedge w_clk);
      n_checks++;
      if ({b_rvalid, a_rvalid} !== 2'b10 || b_rdata !== 32'h55AA55AA) begin
         n_fail++;
         $display("FAIL bread_resp: got b/a rvalid=%b data=%h want 10 55aa55aa",
                  {b_rvalid, a_rvalid}, b_rdata);
      end
      tick();
   endtask

   task test_lock_burst;
      logic exp_b;
      do_reset();
      a_req = 1; a_addr = 12'h020; b_req = 1; b_we = 1; b_addr = 12'h030;
      b_wdata = 32'h0000_1111; b_lock = 1;
      // A 0-3, B burst 4-19, YIELD gives A cycle 20, A 21-23, starve lock at 24.
      for (int c = 0; c < 25; c++) begin
         exp_b = (c >= 4 && c <= 19) || (c == 24);
         @(negedge w_clk);
         n_checks++;
         if ({a_gnt, b_gnt} !== {~exp_b, exp_b}) begin
            n_fail++;
            $display("FAIL lock_gnt c%0d: got a/b=%b want %b", c, {a_gnt, b_gnt}, {~exp_b, exp_b});
         end
         tick();
      end
      b_req = 0;
      @(negedge w_clk);
      n_checks++;
      if ({a_gnt, b_gnt} !== 2'b00) begin
         n_fail++;
         $display("FAIL lock_gap: got a/b=%b want 00", {a_gnt, b_gnt});
      end
      tick();
      b_req = 1; b_lock = 0;
      @(negedge w_clk);
      n_checks++;
      if ({a_gnt, b_gnt} !== 2'b10) begin
         n_fail++;
         $display("FAIL lock_release: got a/b=%b want 10", {a_gnt, b_gnt});
      end
      n_checks++;
      if (a_stall_cnt !== 16'd18) begin
         n_fail++;
         $display("FAIL lock_stall: got %0d want 18", a_stall_cnt);
      end
      tick();
      idle_inputs();
   endtask

   task test_yield_no_relock;
      do_reset();
      b_req = 1; b_we = 1; b_lock = 1; b_addr = 12'h040;
      for (int c = 0; c < 17; c++) begin
         @(negedge w_clk);
         n_checks++;
         if ({a_gnt, b_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL yield_burst c%0d: got a/b=%b want 01", c, {a_gnt, b_gnt});
         end
         tick();
      end
      a_req = 1;
      @(negedge w_clk);
      n_checks++;
      if ({a_gnt, b_gnt} !== 2'b10) begin
         n_fail++;
         $display("FAIL yield_no_relock: got a/b=%b want 10", {a_gnt, b_gnt});
      end
      tick();
      idle_inputs();
   endtask

   task test_reset_mid_lock;
      do_reset();
      b_req = 1; b_lock = 1; b_addr = 12'h123;
      @(negedge w_clk);
      n_checks++;
      if (b_gnt !== 1'b1) begin
         n_fail++;
         $display("FAIL rstlock_enter: got b_gnt=%b want 1", b_gnt);
      end
      tick();
      a_req = 1;
      @(negedge w_clk);
      n_checks++;
      if ({a_gnt, b_gnt} !== 2'b01) begin
         n_fail++;
         $display("FAIL rstlock_block_a: got a/b=%b want 01", {a_gnt, b_gnt});
      end
      tick();
      w_rst = 1; b_we = 1;
      @(negedge w_clk);
      n_checks++;
      if ({a_gnt, b_gnt, mem_we, b_rvalid} !== 4'b0000) begin
         n_fail++;
         $display("FAIL rstlock_during: got a/b/we/rv=%b want 0000", {a_gnt, b_gnt, mem_we, b_rvalid});
      end
      tick();
      w_rst = 0; b_we = 0;
      @(negedge w_clk);
      n_checks++;
      if ({a_gnt, b_gnt, b_rvalid} !== 3'b100 || a_stall_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL rstlock_after: got a/b/rv=%b stall=%0d want 100 0",
                  {a_gnt, b_gnt, b_rvalid}, a_stall_cnt);
      end
      tick();
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      w_rst = 1;
      test_reset();
      test_a_read();
      test_starvation();
      test_b_write_read();
      test_lock_burst();
      test_yield_no_relock();
      test_reset_mid_lock();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
